// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the parallel-to-serial feeder: state encoding and
// the counter sizing rule used by the top level.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  // Counters must hold WIDTH-1 and GAP-1, so size for the larger span.
  function automatic int cnt_width(input int width, input int gap);
    int span;
    span = (width > gap + 1) ? width : gap + 1;
    return (span > 1) ? $clog2(span) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer_hold.sv
// One-deep holding register that parks the next word while the current one
// is shifting; a write on the same edge as a take keeps the buffer full.
module word_hold_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_r;
  logic [WIDTH-1:0] data_r;

  // Capture a parked word, release it when the shifter takes it
  always_ff @(posedge clock) begin
    if (reset) begin
      full_r <= 1'b0;
      data_r <= {WIDTH{1'b0}};
    end else if (wr_valid) begin
      full_r <= 1'b1;
      data_r <= wr_data;
    end else if (take) begin
      full_r <= 1'b0;
    end
  end

  assign wr_ready = ~full_r;
  assign full     = full_r;
  assign data     = data_r;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: words arrive over valid/ready and leave MSB-first
// on x_out, separated by GAP idle bit-times, with one word of look-ahead.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   GAP      = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int             CNT_W    = cnt_width(WIDTH, GAP);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_e           state_r, state_nxt_s;
  logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [CNT_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic             x_out_r, bit_valid_r, frame_start_r;
  logic             x_nxt_s, bit_valid_nxt_s, frame_start_nxt_s;

  logic             accept_s, direct_s, take_s;
  logic             hold_ready_s, hold_full_s;
  logic [WIDTH-1:0] hold_data_s;

  assign accept_s = load_valid & hold_ready_s;

  word_hold_buffer #(.WIDTH(WIDTH)) u_hold (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (accept_s & ~direct_s),
    .wr_data  (data_in),
    .wr_ready (hold_ready_s),
    .take     (take_s),
    .full     (hold_full_s),
    .data     (hold_data_s)
  );

  // State, datapath and registered output update
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      shreg_r       <= {WIDTH{1'b0}};
      bit_cnt_r     <= CNT_ZERO;
      gap_cnt_r     <= CNT_ZERO;
      x_out_r       <= IDLE_BIT;
      bit_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      shreg_r       <= shreg_nxt_s;
      bit_cnt_r     <= bit_cnt_nxt_s;
      gap_cnt_r     <= gap_cnt_nxt_s;
      x_out_r       <= x_nxt_s;
      bit_valid_r   <= bit_valid_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  // Next-state: a frame boundary with an empty hold takes a fresh word straight
  // into the shifter, so a word offered on that edge never stalls in IDLE.
  always_comb begin
    state_nxt_s   = state_r;
    shreg_nxt_s   = shreg_r;
    bit_cnt_nxt_s = bit_cnt_r;
    gap_cnt_nxt_s = gap_cnt_r;
    take_s        = 1'b0;
    direct_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hold_full_s) begin
          state_nxt_s   = ST_SHIFT;
          shreg_nxt_s   = hold_data_s;
          bit_cnt_nxt_s = BIT_LOAD;
          take_s        = 1'b1;
        end else if (accept_s) begin
          state_nxt_s   = ST_SHIFT;
          shreg_nxt_s   = data_in;
          bit_cnt_nxt_s = BIT_LOAD;
          direct_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_r != CNT_ZERO) begin
          shreg_nxt_s   = {shreg_r[WIDTH-2:0], 1'b0};
          bit_cnt_nxt_s = bit_cnt_r - CNT_ONE;
        end else if (GAP > 0) begin
          state_nxt_s   = ST_GAP;
          gap_cnt_nxt_s = GAP_LOAD;
        end else if (hold_full_s) begin
          shreg_nxt_s   = hold_data_s;
          bit_cnt_nxt_s = BIT_LOAD;
          take_s        = 1'b1;
        end else if (accept_s) begin
          shreg_nxt_s   = data_in;
          bit_cnt_nxt_s = BIT_LOAD;
          direct_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r != CNT_ZERO) begin
          gap_cnt_nxt_s = gap_cnt_r - CNT_ONE;
        end else if (hold_full_s) begin
          state_nxt_s   = ST_SHIFT;
          shreg_nxt_s   = hold_data_s;
          bit_cnt_nxt_s = BIT_LOAD;
          take_s        = 1'b1;
        end else if (accept_s) begin
          state_nxt_s   = ST_SHIFT;
          shreg_nxt_s   = data_in;
          bit_cnt_nxt_s = BIT_LOAD;
          direct_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, registered above
  always_comb begin
    x_nxt_s           = IDLE_BIT;
    bit_valid_nxt_s   = 1'b0;
    frame_start_nxt_s = 1'b0;
    if (state_nxt_s == ST_SHIFT) begin
      x_nxt_s           = shreg_nxt_s[WIDTH-1];
      bit_valid_nxt_s   = 1'b1;
      frame_start_nxt_s = (bit_cnt_nxt_s == BIT_LOAD);
    end else begin
      x_nxt_s           = IDLE_BIT;
      bit_valid_nxt_s   = 1'b0;
      frame_start_nxt_s = 1'b0;
    end
  end

  assign x_out       = x_out_r;
  assign bit_valid   = bit_valid_r;
  assign frame_start = frame_start_r;
  assign load_ready  = hold_ready_s;
  assign busy        = (state_r != ST_IDLE) | hold_full_s;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (GAP=1 and GAP=0) share stimulus and
// are checked against a per-instance queue of expected output symbols.
module tb_bit_serializer;

  localparam int   WIDTH    = 8;
  localparam logic IDLE_BIT = 1'b0;
  localparam int   DEPTH    = 64;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] data_in;

  logic load_ready_a  [2];
  logic x_out_a       [2];
  logic bit_valid_a   [2];
  logic frame_start_a [2];
  logic busy_a        [2];

  always #5 clock = ~clock;

  bit_serializer #(.WIDTH(WIDTH), .GAP(1), .IDLE_BIT(IDLE_BIT)) u_dut_g1 (
    .clock(clock), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready_a[0]), .x_out(x_out_a[0]), .bit_valid(bit_valid_a[0]),
    .frame_start(frame_start_a[0]), .busy(busy_a[0])
  );

  bit_serializer #(.WIDTH(WIDTH), .GAP(0), .IDLE_BIT(IDLE_BIT)) u_dut_g0 (
    .clock(clock), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready_a[1]), .x_out(x_out_a[1]), .bit_valid(bit_valid_a[1]),
    .frame_start(frame_start_a[1]), .busy(busy_a[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: each instance owns a FIFO of future output symbols {fs, valid, x}.
  // An accepted word appends WIDTH data symbols plus its idle gap to the end.
  logic [2:0] mq [2][DEPTH];
  int         mhead [2];
  int         mcnt  [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic logic [2:0] head_sym(input int k);
    if (mcnt[k] > 0) return mq[k][mhead[k]];
    return {1'b0, 1'b0, IDLE_BIT};
  endfunction

  // Words queued but not yet on the line occupy the holding buffer
  function automatic int unstarted(input int k);
    int n = 0;
    for (int i = 1; i < mcnt[k]; i++)
      if (mq[k][(mhead[k] + i) % DEPTH][2]) n++;
    return n;
  endfunction

  task automatic push_sym(input int k, input logic [2:0] s);
    mq[k][(mhead[k] + mcnt[k]) % DEPTH] = s;
    mcnt[k]++;
  endtask

  task automatic advance(input int k, input logic acc, input logic [7:0] w, input logic rst);
    if (rst) begin
      mhead[k] = 0;
      mcnt[k]  = 0;
    end else begin
      if (mcnt[k] > 0) begin
        mhead[k] = (mhead[k] + 1) % DEPTH;
        mcnt[k]--;
      end
      if (acc) begin
        for (int b = WIDTH - 1; b >= 0; b--)
          push_sym(k, {(b == WIDTH - 1), 1'b1, w[b]});
        for (int g = 0; g < gap_of(k); g++)
          push_sym(k, {1'b0, 1'b0, IDLE_BIT});
      end
    end
  endtask

  string nm [2] = '{"g1", "g0"};

  // Check current outputs mid-cycle, drive next inputs, step the model at the edge
  task automatic run_cycle(input logic rst, input logic valid, input logic [7:0] data);
    logic       acc [2];
    logic [2:0] s;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      s = head_sym(k);
      check_eq({nm[k], ".x_out"},       {31'd0, x_out_a[k]},       {31'd0, s[0]});
      check_eq({nm[k], ".bit_valid"},   {31'd0, bit_valid_a[k]},   {31'd0, s[1]});
      check_eq({nm[k], ".frame_start"}, {31'd0, frame_start_a[k]}, {31'd0, s[2]});
      check_eq({nm[k], ".load_ready"},  {31'd0, load_ready_a[k]},  {31'd0, (unstarted(k) == 0)});
      check_eq({nm[k], ".busy"},        {31'd0, busy_a[k]},        {31'd0, (mcnt[k] > 0)});
    end
    reset      = rst;
    load_valid = valid;
    data_in    = data;
    for (int k = 0; k < 2; k++) acc[k] = valid && !rst && (unstarted(k) == 0);
    @(posedge clock);
    for (int k = 0; k < 2; k++) advance(k, acc[k], data, rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0;
      mcnt[k]  = 0;
    end
    reset      = 1'b1;
    load_valid = 1'b0;
    data_in    = 8'h00;
    @(posedge clock);
    run_cycle(1'b1, 1'b0, 8'h00);
    run_cycle(1'b1, 1'b0, 8'h00);
    idle(3);

    // Single word into an idle block
    run_cycle(1'b0, 1'b1, 8'hA5);
    idle(12);

    // Second word offered mid-word lands in the holding buffer
    run_cycle(1'b0, 1'b1, 8'hF0);
    idle(3);
    run_cycle(1'b0, 1'b1, 8'h0F);
    idle(16);

    // Back-to-back stream
    run_cycle(1'b0, 1'b1, 8'hFF);
    run_cycle(1'b0, 1'b1, 8'h00);
    idle(20);

    // Valid held high with changing data while the hold is full
    run_cycle(1'b0, 1'b1, 8'hF0);
    run_cycle(1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 8'($urandom));
    load_valid = 1'b0;
    idle(25);

    // Reset at the 4th bit with a word parked in hold
    run_cycle(1'b0, 1'b1, 8'hC3);
    run_cycle(1'b0, 1'b1, 8'h3C);
    idle(2);
    run_cycle(1'b1, 1'b0, 8'h00);
    idle(12);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 800; i++)
      run_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), 8'($urandom));
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
